// File: rtl/pc_gen_pkg.sv
// Shared types and default constants for the program-counter generator.
// The reset address and hold threshold here are the defaults used by pc_gen.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } pcg_state_t;

    localparam logic [31:0] CPU_RESET_ADDR = 32'h0000_0000;
    localparam int          HOLD_PC        = 1;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux with jump-target alignment check.
// A misaligned jump is diverted to the trap vector and flagged.
module pc_next_sel #(
    parameter int ADDR_W        = 32,
    parameter int STEP          = 4,
    parameter int HOLD_W        = 3,
    parameter int HOLD_PC_LEVEL = 1
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              redirect_en,
    input  logic              advance,
    input  logic              trap_flag,
    input  logic [ADDR_W-1:0] trap_addr,
    input  logic              jump_flag,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic [HOLD_W-1:0] hold_flag,
    output logic [ADDR_W-1:0] next_pc,
    output logic              redirect,
    output logic              misalign
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);

    logic jump_aligned;
    assign jump_aligned = (jump_addr & ALIGN_MASK) == '0;

    // Redirects outrank hold and backpressure; a trap always beats a jump.
    always_comb begin
        next_pc  = pc;
        redirect = 1'b0;
        misalign = 1'b0;
        if (redirect_en && trap_flag) begin
            next_pc  = trap_addr;
            redirect = 1'b1;
        end else if (redirect_en && jump_flag && jump_aligned) begin
            next_pc  = jump_addr;
            redirect = 1'b1;
        end else if (redirect_en && jump_flag) begin
            next_pc  = trap_addr;
            redirect = 1'b1;
            misalign = 1'b1;
        end else if (hold_flag >= HOLD_W'(HOLD_PC_LEVEL)) begin
            next_pc = pc;
        end else if (advance) begin
            next_pc = pc + ADDR_W'(STEP);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: boot/run/halt FSM with a valid/ready fetch handshake.
// Next-PC selection lives in pc_next_sel; all outputs here are registered.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR    = ADDR_W'(CPU_RESET_ADDR),
    parameter int                STEP          = 4,
    parameter int                HOLD_W        = 3,
    parameter int                HOLD_PC_LEVEL = HOLD_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jtag_reset_flag,
    input  logic              jtag_halt_req,
    input  logic              trap_flag,
    input  logic [ADDR_W-1:0] trap_addr,
    input  logic              jump_flag,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic [HOLD_W-1:0] hold_flag,
    input  logic              fetch_ready,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    output logic              redirect_o,
    output logic              misalign_o,
    output logic              halted_o
);

    pcg_state_t        state;
    logic [ADDR_W-1:0] next_pc;
    logic              sel_redirect;
    logic              sel_misalign;
    logic              advance;
    logic              redirect_en;

    assign advance     = (state == S_RUN) && pc_valid_o && fetch_ready;
    assign redirect_en = (state != S_BOOT);

    pc_next_sel #(
        .ADDR_W        (ADDR_W),
        .STEP          (STEP),
        .HOLD_W        (HOLD_W),
        .HOLD_PC_LEVEL (HOLD_PC_LEVEL)
    ) u_next_sel (
        .pc          (pc_o),
        .redirect_en (redirect_en),
        .advance     (advance),
        .trap_flag   (trap_flag),
        .trap_addr   (trap_addr),
        .jump_flag   (jump_flag),
        .jump_addr   (jump_addr),
        .hold_flag   (hold_flag),
        .next_pc     (next_pc),
        .redirect    (sel_redirect),
        .misalign    (sel_misalign)
    );

    // A redirect in RUN keeps us running even with a halt request pending;
    // in HALT a redirect moves the PC but the block stays halted.
    always_ff @(posedge clk) begin
        if (!rst || jtag_reset_flag) begin
            state      <= S_BOOT;
            pc_o       <= RESET_ADDR;
            pc_valid_o <= 1'b0;
            redirect_o <= 1'b0;
            misalign_o <= 1'b0;
            halted_o   <= 1'b0;
        end else begin
            pc_o       <= next_pc;
            redirect_o <= sel_redirect;
            misalign_o <= sel_misalign;
            case (state)
                S_BOOT: begin
                    state      <= S_RUN;
                    pc_valid_o <= 1'b1;
                    halted_o   <= 1'b0;
                end
                S_RUN: begin
                    if (jtag_halt_req && !sel_redirect) begin
                        state      <= S_HALT;
                        pc_valid_o <= 1'b0;
                        halted_o   <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (!jtag_halt_req) begin
                        state      <= S_RUN;
                        pc_valid_o <= 1'b1;
                        halted_o   <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_BOOT;
                    pc_valid_o <= 1'b0;
                    halted_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scenario bench for pc_gen: each task queues expected outputs as it drives a
// cycle and pops them after the clock edge; a 16-bit instance covers wrap.
module tb_pc_gen;

    typedef struct packed {
        logic        rst;
        logic        jreset;
        logic        halt;
        logic        trap;
        logic [31:0] taddr;
        logic        jump;
        logic [31:0] jaddr;
        logic [2:0]  hold;
        logic        ready;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        redirect;
        logic        misalign;
        logic        halted;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        jtag_reset_flag;
    logic        jtag_halt_req;
    logic        trap_flag;
    logic [31:0] trap_addr;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic [2:0]  hold_flag;
    logic        fetch_ready;
    logic [31:0] pc_o;
    logic        pc_valid_o, redirect_o, misalign_o, halted_o;
    logic [15:0] pc16_o;
    logic        pc16_valid, pc16_redirect, pc16_misalign, pc16_halted;

    obs_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk             (clk),
        .rst             (rst),
        .jtag_reset_flag (jtag_reset_flag),
        .jtag_halt_req   (jtag_halt_req),
        .trap_flag       (trap_flag),
        .trap_addr       (trap_addr),
        .jump_flag       (jump_flag),
        .jump_addr       (jump_addr),
        .hold_flag       (hold_flag),
        .fetch_ready     (fetch_ready),
        .pc_o            (pc_o),
        .pc_valid_o      (pc_valid_o),
        .redirect_o      (redirect_o),
        .misalign_o      (misalign_o),
        .halted_o        (halted_o)
    );

    pc_gen #(.ADDR_W(16)) dut16 (
        .clk             (clk),
        .rst             (rst),
        .jtag_reset_flag (jtag_reset_flag),
        .jtag_halt_req   (jtag_halt_req),
        .trap_flag       (trap_flag),
        .trap_addr       (trap_addr[15:0]),
        .jump_flag       (jump_flag),
        .jump_addr       (jump_addr[15:0]),
        .hold_flag       (hold_flag),
        .fetch_ready     (fetch_ready),
        .pc_o            (pc16_o),
        .pc_valid_o      (pc16_valid),
        .redirect_o      (pc16_redirect),
        .misalign_o      (pc16_misalign),
        .halted_o        (pc16_halted)
    );

    function automatic stim_t st(input logic ready, input logic [2:0] hold = 3'd0,
                                 input logic halt = 1'b0, input logic trap = 1'b0,
                                 input logic [31:0] taddr = 32'h0, input logic jump = 1'b0,
                                 input logic [31:0] jaddr = 32'h0, input logic rstn = 1'b1,
                                 input logic jreset = 1'b0);
        stim_t s;
        s.rst = rstn; s.jreset = jreset; s.halt = halt; s.trap = trap; s.taddr = taddr;
        s.jump = jump; s.jaddr = jaddr; s.hold = hold; s.ready = ready;
        return s;
    endfunction

    function automatic obs_t ob(input logic [31:0] pc, input logic valid,
                                input logic red = 1'b0, input logic mis = 1'b0,
                                input logic hlt = 1'b0);
        obs_t o;
        o.pc = pc; o.valid = valid; o.redirect = red; o.misalign = mis; o.halted = hlt;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.pc = pc_o; o.valid = pc_valid_o; o.redirect = redirect_o;
        o.misalign = misalign_o; o.halted = halted_o;
        return o;
    endfunction

    task automatic drive(input stim_t s);
        rst             = s.rst;
        jtag_reset_flag = s.jreset;
        jtag_halt_req   = s.halt;
        trap_flag       = s.trap;
        trap_addr       = s.taddr;
        jump_flag       = s.jump;
        jump_addr       = s.jaddr;
        hold_flag       = s.hold;
        fetch_ready     = s.ready;
    endtask

    task automatic test_reset();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, exp;
        s.push_back(st(1, 3'd0, 0, 1, 32'h80, 0, 0, 0)); e.push_back(ob(32'h0, 0));
        s.push_back(st(1, 3'd0, 0, 0, 0, 0, 0, 0));      e.push_back(ob(32'h0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = sample();
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL reset step %0d: got pc=%h v%b r%b m%b h%b, expected pc=%h v%b r%b m%b h%b",
                         i, got.pc, got.valid, got.redirect, got.misalign, got.halted,
                         exp.pc, exp.valid, exp.redirect, exp.misalign, exp.halted);
            end
        end
    endtask

    task automatic test_run_backpressure();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, exp;
        s.push_back(st(1)); e.push_back(ob(32'h00, 1));
        s.push_back(st(1)); e.push_back(ob(32'h04, 1));
        s.push_back(st(1)); e.push_back(ob(32'h08, 1));
        s.push_back(st(1)); e.push_back(ob(32'h0C, 1));
        s.push_back(st(1)); e.push_back(ob(32'h10, 1));
        for (int k = 0; k < 3; k++) begin
            s.push_back(st(0)); e.push_back(ob(32'h10, 1));
        end
        s.push_back(st(0, 3'd0, 0, 0, 0, 1, 32'h200)); e.push_back(ob(32'h200, 1, 1));
        s.push_back(st(0));                            e.push_back(ob(32'h200, 1));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = sample();
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL run_backpressure step %0d: got pc=%h v%b r%b m%b h%b, expected pc=%h v%b r%b m%b h%b",
                         i, got.pc, got.valid, got.redirect, got.misalign, got.halted,
                         exp.pc, exp.valid, exp.redirect, exp.misalign, exp.halted);
            end
        end
    endtask

    task automatic test_misalign();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, exp;
        s.push_back(st(0, 3'd0, 0, 0, 32'h80, 1, 32'h102)); e.push_back(ob(32'h80, 1, 1, 1));
        s.push_back(st(0, 3'd0, 0, 0, 32'h80));             e.push_back(ob(32'h80, 1));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = sample();
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL misalign step %0d: got pc=%h v%b r%b m%b h%b, expected pc=%h v%b r%b m%b h%b",
                         i, got.pc, got.valid, got.redirect, got.misalign, got.halted,
                         exp.pc, exp.valid, exp.redirect, exp.misalign, exp.halted);
            end
        end
    endtask

    task automatic test_trap_vs_jump();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, exp;
        s.push_back(st(1));                                   e.push_back(ob(32'h84, 1));
        s.push_back(st(1, 3'd3, 0, 1, 32'h80, 1, 32'h302));  e.push_back(ob(32'h80, 1, 1, 0));
        s.push_back(st(1, 3'd3));                             e.push_back(ob(32'h80, 1));
        s.push_back(st(1, 3'd1));                             e.push_back(ob(32'h80, 1));
        s.push_back(st(1, 3'd0));                             e.push_back(ob(32'h84, 1));
        s.push_back(st(0, 3'd3, 0, 0, 0, 1, 32'h300));       e.push_back(ob(32'h300, 1, 1));
        s.push_back(st(0));                                   e.push_back(ob(32'h300, 1));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = sample();
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL trap_vs_jump step %0d: got pc=%h v%b r%b m%b h%b, expected pc=%h v%b r%b m%b h%b",
                         i, got.pc, got.valid, got.redirect, got.misalign, got.halted,
                         exp.pc, exp.valid, exp.redirect, exp.misalign, exp.halted);
            end
        end
    endtask

    task automatic test_wrap();
        obs_t got, exp;
        drive(st(0, 3'd0, 0, 0, 0, 1, 32'hFFFF_FFFC));
        exp_q.push_back(ob(32'hFFFF_FFFC, 1, 1));
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        got = sample();
        vectors += 2;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL wrap_load: got pc=%h v%b r%b, expected pc=%h v%b r%b",
                     got.pc, got.valid, got.redirect, exp.pc, exp.valid, exp.redirect);
        end
        if (pc16_o !== 16'hFFFC) begin
            errors++;
            $display("[TB] FAIL wrap16_load: got pc=%h, expected pc=fffc", pc16_o);
        end
        drive(st(1));
        exp_q.push_back(ob(32'h0, 1));
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        got = sample();
        vectors += 2;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL wrap_step: got pc=%h v%b r%b, expected pc=%h v%b r%b",
                     got.pc, got.valid, got.redirect, exp.pc, exp.valid, exp.redirect);
        end
        if (pc16_o !== 16'h0000 || pc16_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap16_step: got pc=%h v%b, expected pc=0000 v1", pc16_o, pc16_valid);
        end
    endtask

    task automatic test_halt();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, exp;
        s.push_back(st(0, 3'd0, 0, 0, 0, 1, 32'h40));        e.push_back(ob(32'h40, 1, 1));
        s.push_back(st(0, 3'd0, 1));                          e.push_back(ob(32'h40, 0, 0, 0, 1));
        s.push_back(st(1, 3'd0, 1));                          e.push_back(ob(32'h40, 0, 0, 0, 1));
        s.push_back(st(0, 3'd0, 1, 0, 0, 1, 32'h500));       e.push_back(ob(32'h500, 0, 1, 0, 1));
        s.push_back(st(0, 3'd0, 1));                          e.push_back(ob(32'h500, 0, 0, 0, 1));
        s.push_back(st(0));                                   e.push_back(ob(32'h500, 1));
        s.push_back(st(0, 3'd0, 1, 0, 0, 1, 32'h600));       e.push_back(ob(32'h600, 1, 1));
        s.push_back(st(0, 3'd0, 1));                          e.push_back(ob(32'h600, 0, 0, 0, 1));
        s.push_back(st(1));                                   e.push_back(ob(32'h600, 1));
        s.push_back(st(1));                                   e.push_back(ob(32'h604, 1));
        s.push_back(st(1, 3'd0, 0, 0, 0, 0, 0, 1, 1));       e.push_back(ob(32'h0, 0));
        s.push_back(st(1));                                   e.push_back(ob(32'h0, 1));
        s.push_back(st(1));                                   e.push_back(ob(32'h4, 1));
        s.push_back(st(1, 3'd3, 1));                          e.push_back(ob(32'h4, 0, 0, 0, 1));
        s.push_back(st(1));                                   e.push_back(ob(32'h4, 1));
        s.push_back(st(1, 3'd0, 0, 1, 32'h80, 0, 0, 0));     e.push_back(ob(32'h0, 0));
        s.push_back(st(1, 3'd0, 0, 0, 0, 1, 32'h300));       e.push_back(ob(32'h0, 1));
        s.push_back(st(1));                                   e.push_back(ob(32'h4, 1));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = sample();
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL halt step %0d: got pc=%h v%b r%b m%b h%b, expected pc=%h v%b r%b m%b h%b",
                         i, got.pc, got.valid, got.redirect, got.misalign, got.halted,
                         exp.pc, exp.valid, exp.redirect, exp.misalign, exp.halted);
            end
        end
    endtask

    initial begin
        drive(st(0, 3'd0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_run_backpressure();
        test_misalign();
        test_trap_vs_jump();
        test_wrap();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator, the successor of the single-width PC register. It drives the instruction-fetch address, supports trap and jump redirects with fixed priority, and checks jump-target alignment. It adds a valid/ready handshake toward fetch and a JTAG halt state. It sits at the head of the fetch stage and feeds the bus/ifetch unit and the IF/ID pipeline register.

## Interface
Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset or JTAG reset.
- STEP, 4, sequential increment in bytes; must be a power of two.
- HOLD_W, 3, width of hold_flag.
- HOLD_PC_LEVEL, 1, hold_flag value at or above which the PC freezes.

Ports:
- clk, in, 1, core clock.
- rst, in, 1, synchronous active-low reset.
- jtag_reset_flag, in, 1, debug reset; same effect as rst, active-high.
- jtag_halt_req, in, 1, level request to halt fetch.
- trap_flag, in, 1, exception/interrupt redirect request.
- trap_addr, in, ADDR_W, trap vector.
- jump_flag, in, 1, branch/jump redirect request.
- jump_addr, in, ADDR_W, jump target.
- hold_flag, in, HOLD_W, pipeline hold level.
- fetch_ready, in, 1, fetch unit accepts pc_o this cycle.
- pc_o, out, ADDR_W, current fetch address.
- pc_valid_o, out, 1, pc_o is a fetch request.
- redirect_o, out, 1, one-cycle pulse: pc_o was just loaded from trap, jump or misalign path.
- misalign_o, out, 1, one-cycle pulse: jump_addr was not STEP-aligned.
- halted_o, out, 1, block is in HALT.

## Operation
- All outputs are registered. Reset values: pc_o=RESET_ADDR, pc_valid_o=0, redirect_o=0, misalign_o=0, halted_o=0, state=S_BOOT.
- FSM states: S_BOOT, S_RUN, S_HALT.
  - S_BOOT lasts one cycle after reset, then moves to S_RUN with pc_valid_o=1.
  - S_RUN moves to S_HALT when jtag_halt_req=1 and no redirect is active that cycle. In S_HALT: pc_valid_o=0, halted_o=1.
  - S_HALT moves to S_RUN when jtag_halt_req=0. pc_o is unchanged and pc_valid_o=1 on the next cycle.
- Next-PC priority, highest first:
  1. rst=0 or jtag_reset_flag=1: load RESET_ADDR and enter S_BOOT.
  2. trap_flag: pc_o<=trap_addr, redirect_o=1.
  3. jump_flag with jump_addr[log2(STEP)-1:0]==0: pc_o<=jump_addr, redirect_o=1.
  4. jump_flag with misaligned jump_addr: pc_o<=trap_addr, redirect_o=1, misalign_o=1.
  5. hold_flag>=HOLD_PC_LEVEL: pc_o unchanged.
  6. S_RUN with pc_valid_o and fetch_ready both 1: pc_o<=pc_o+STEP.
  7. Otherwise: pc_o unchanged.
- Redirects (priorities 2–4) are honoured in every state except S_BOOT. In S_HALT they update pc_o and the block stays halted.
- A redirect overrides hold and overrides fetch_ready=0.
- Increment is modulo 2^ADDR_W: pc_o at the top address minus STEP+1 wraps to 0 with no flag.
- trap_flag and jump_flag in the same cycle: the trap wins, the jump is dropped, and misalign_o=0 even if jump_addr is misaligned.

## Timing
- Redirect latency is 1 cycle: a request sampled at edge N gives the new pc_o after edge N, with redirect_o high for that one cycle.
- Handshake: pc_o/pc_valid_o stay stable while pc_valid_o=1 and fetch_ready=0. Only a redirect may change pc_o during backpressure.
- Reset is sampled on the clock edge only; rst asserted mid-stream aborts any pending advance or redirect.
- After rst is released, the first valid fetch of RESET_ADDR occurs 1 cycle later (the S_BOOT cycle).
- Halt takes effect 1 cycle after jtag_halt_req rises. A halt requested while hold is active still enters S_HALT.

## Structure
- defines.v holds: FSM state encodings (`pcg_boot`, `pcg_run`, `pcg_halt`), `cpu_reset_addr` (default for RESET_ADDR), `hold_pc` (default for HOLD_PC_LEVEL), `rst_enable` redefined as 1'b0 for active-low.
- One natural sub-module: pc_next_sel, a combinational priority mux plus alignment check producing next_pc, redirect and misalign. The FSM and registers stay in pc_gen.

## Test plan
- Reset then run with fetch_ready=1: pc_o sequence 0x0 (valid from cycle 1), 0x4, 0x8, 0xC.
- fetch_ready=0 for 3 cycles at pc_o=0x10: pc_o holds 0x10, valid=1. Then jump_flag with 0x200 under backpressure: pc_o=0x200, redirect_o pulses once.
- jump_addr=0x102 with trap_addr=0x80: pc_o=0x80, redirect_o=1 and misalign_o=1 for exactly one cycle.
- trap_flag (0x80) and jump_flag (0x300) in the same cycle with hold_flag=3'd3: pc_o=0x80, misalign_o=0. With only hold_flag=3, pc_o freezes.
- ADDR_W=16, pc_o=0xFFFC, fetch_ready=1: next pc_o=0x0000.
- jtag_halt_req=1 at pc_o=0x40: halted_o=1, valid=0. Jump to 0x500 while halted: pc_o=0x500, stays halted. Release the request: valid=1 at 0x500. Then jtag_reset_flag=1: pc_o=RESET_ADDR, valid=0 for 1 cycle.
